// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Op codes, FSM states, and a conditional two's-complement negate used for magnitudes and sign fix.
package muldiv_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2
    } state_e;

    // Callers zero-extend into MAX_W bits and size-cast the result back down.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int WORD_SIZE = 32);
    logic                 start;
    logic [2:0]           op;
    logic [WORD_SIZE-1:0] rs_data;
    logic [WORD_SIZE-1:0] rt_data;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] hi;
    logic [WORD_SIZE-1:0] lo;

    modport master (output start, op, rs_data, rt_data, flush, input busy, done, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for muldiv: IDLE -> RUN (WORD_SIZE steps) -> SIGN -> IDLE, with flush abort.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int WORD_SIZE = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic flush,
    output logic busy,
    output logic done,
    output logic step,
    output logic finish
);
    localparam int CNT_W = $clog2(WORD_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SIZE - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: if (load) state_nxt = S_RUN;
            S_RUN: begin
                step = ~flush;
                if (flush)            state_nxt = S_IDLE;
                else if (cnt == LAST) state_nxt = S_SIGN;
            end
            S_SIGN: begin
                finish    = ~flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            cnt  <= step ? cnt + 1'b1 : '0;
            // done lands in the same cycle hi/lo are first visible
            done <= finish;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply, restoring divide, sign fix on exit.
module muldiv import muldiv_pkg::*; #(
    parameter int WORD_SIZE = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int W = WORD_SIZE;

    op_e            op;
    logic           busy, done, load, step, finish, accept, op_div, op_sgn;
    logic [W-1:0]   rs_mag, rt_mag, acc, lq, opnd, hi_q, lo_q, hi_nxt, lo_nxt;
    logic           is_div, neg_res, neg_rem, div0, div_ge;
    logic [W:0]     mul_sum, div_shl, div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    assign op     = op_e'(bus.op);
    assign accept = bus.start & ~busy & ~bus.flush;
    assign load   = accept & ~bus.op[2];
    assign op_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign rs_mag = W'(cond_neg(MAX_W'(bus.rs_data), op_sgn & bus.rs_data[W-1]));
    assign rt_mag = W'(cond_neg(MAX_W'(bus.rt_data), op_sgn & bus.rt_data[W-1]));

    // Multiply: acc is the product's upper half, lq the lower half still holding unused multiplier bits.
    assign mul_sum  = {1'b0, acc} + {1'b0, (lq[0] ? opnd : '0)};
    // Divide: acc is the partial remainder, lq shifts dividend bits out and quotient bits in.
    assign div_shl  = {acc, lq[W-1]};
    assign div_ge   = div_shl >= {1'b0, opnd};
    assign div_diff = div_shl - {1'b0, opnd};

    assign prod_fix = (2*W)'(cond_neg(MAX_W'({acc, lq}), neg_res));
    assign quot_fix = W'(cond_neg(MAX_W'(lq), neg_res));
    assign rem_fix  = W'(cond_neg(MAX_W'(acc), neg_rem));

    // With a zero divisor the remainder ends up as |rs|, so the dividend-sign fix returns rs unchanged.
    assign hi_nxt = is_div ? rem_fix : prod_fix[2*W-1:W];
    assign lo_nxt = is_div ? (div0 ? '1 : quot_fix) : prod_fix[W-1:0];

    muldiv_ctrl #(.WORD_SIZE(W)) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .flush  (bus.flush),
        .busy   (busy),
        .done   (done),
        .step   (step),
        .finish (finish)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            acc     <= '0;
            lq      <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            if (accept && op == OP_MTHI) hi_q <= bus.rs_data;
            if (accept && op == OP_MTLO) lo_q <= bus.rs_data;
            if (load) begin
                acc     <= '0;
                opnd    <= op_div ? rt_mag : rs_mag;
                lq      <= op_div ? rs_mag : rt_mag;
                is_div  <= op_div;
                neg_res <= op_sgn & (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
                neg_rem <= op_sgn & bus.rs_data[W-1];
                div0    <= (bus.rt_data == '0);
            end else if (step) begin
                if (is_div) begin
                    acc <= div_ge ? W'(div_diff) : W'(div_shl);
                    lq  <= {lq[W-2:0], div_ge};
                end else begin
                    acc <= mul_sum[W:1];
                    lq  <= {mul_sum[0], lq[W-1:1]};
                end
            end
            if (finish) begin
                hi_q <= hi_nxt;
                lo_q <= lo_nxt;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Scenario bench for muldiv: expected HI/LO pushed at issue, popped and compared on done.
module tb_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp = '0;

    muldiv_if #(.WORD_SIZE(W)) bus();

    muldiv #(.WORD_SIZE(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb_);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(a % b), 32'(a / b)};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        tick();
        bus.start = 1'b0;
        if (op < 3'd4) sb.push_back(model(op, a, b));
    endtask

    // Cycle numbering: the accept cycle is 0; call at cycle cyc0 with cyc0 >= 1.
    task automatic wait_done(input int cyc0, output int cyc, output int busy_cnt);
        cyc = cyc0;
        busy_cnt = cyc0 - 1;
        while (!bus.done && cyc < 200) begin
            if (bus.busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (!bus.done) cyc = -1;
    endtask

    function automatic logic [63:0] pop_exp();
        if (sb.size() == 0) return '1;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_data = '0; bus.rt_data = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        vectors++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int cyc, bc;
        logic [63:0] exp;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, cyc, bc);
        vectors++;
        if (cyc !== 34) begin
            miscompares++;
            $display("FAIL multu_latency: done at cycle %0d want 34", cyc);
        end
        vectors++;
        if (bc !== 33) begin
            miscompares++;
            $display("FAIL multu_busy: busy cycles %0d want 33", bc);
        end
        exp = pop_exp();
        last_exp = exp;
        vectors++;
        if ({bus.hi, bus.lo} !== exp || exp !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL multu_result: got %h want %h", {bus.hi, bus.lo}, exp);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL multu_busy_at_done: busy=%b want 0", bus.busy);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL multu_done_pulse: done=%b want 0", bus.done);
        end
    endtask

    // Each op issues in the done cycle of the previous one.
    task automatic run_seq(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc, bc;
        logic [63:0] exp;
        issue(op, a, b);
        wait_done(1, cyc, bc);
        exp = pop_exp();
        last_exp = exp;
        vectors++;
        if (cyc !== 34 || {bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL %s: cycle %0d hi/lo %h want cycle 34 hi/lo %h", name, cyc, {bus.hi, bus.lo}, exp);
        end
    endtask

    task automatic test_signed();
        run_seq("mult_neg7x6", 3'd0, 32'hFFFF_FFF9, 32'd6);
        run_seq("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_seq("mult_negxneg", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_seq("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd10);
    endtask

    task automatic test_div_edge();
        run_seq("divu_by_zero", 3'd3, 32'd100, 32'd0);
        run_seq("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_seq("div_neg_by_zero", 3'd2, 32'hFFFF_FFF9, 32'd0);
        run_seq("div_rem_sign", 3'd2, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_mthi_mtlo();
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_data = 32'h1234_5678;
        tick();
        vectors++;
        if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: hi=%h busy=%b done=%b want 12345678 0 0", bus.hi, bus.busy, bus.done);
        end
        bus.op = 3'd5; bus.rs_data = 32'h9ABC_DEF0;
        tick();
        vectors++;
        if ({bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: hi/lo=%h busy=%b done=%b want 123456789abcdef0 0 0", {bus.hi, bus.lo}, bus.busy, bus.done);
        end
        bus.op = 3'd6; bus.rs_data = 32'h5555_5555; bus.rt_data = 32'd3;
        tick();
        bus.op = 3'd7;
        tick();
        bus.start = 1'b0;
        tick();
        vectors++;
        if ({bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reserved_op: hi/lo=%h busy=%b want unchanged, busy 0", {bus.hi, bus.lo}, bus.busy);
        end
        last_exp = 64'h1234_5678_9ABC_DEF0;
    endtask

    task automatic test_busy_ignore();
        int cyc, bc, seen;
        logic [63:0] exp;
        issue(3'd3, 32'd50, 32'd7);
        tick(); tick(); tick();
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
        tick();
        bus.start = 1'b0;
        wait_done(5, cyc, bc);
        exp = pop_exp();
        last_exp = exp;
        vectors++;
        if (cyc !== 34 || {bus.hi, bus.lo} !== exp || exp !== {32'd1, 32'd7}) begin
            miscompares++;
            $display("FAIL busy_ignore: cycle %0d hi/lo %h want cycle 34 hi/lo %h", cyc, {bus.hi, bus.lo}, exp);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy || bus.done) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL busy_not_queued: %0d busy/done cycles want 0", seen);
        end
    endtask

    task automatic test_flush();
        int seen;
        issue(3'd0, 32'd3, 32'd4);
        void'(sb.pop_back());
        for (int c = 1; c < 10; c++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_run_busy: busy=%b want 0", bus.busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen++;
        end
        vectors++;
        if (seen !== 0 || {bus.hi, bus.lo} !== last_exp) begin
            miscompares++;
            $display("FAIL flush_run_result: done %0d times hi/lo %h want 0 times hi/lo %h", seen, {bus.hi, bus.lo}, last_exp);
        end
        // Flush in the same cycle as start: nothing is accepted.
        bus.flush = 1'b1;
        issue(3'd1, 32'd5, 32'd5);
        bus.flush = 1'b0;
        void'(sb.pop_back());
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_with_start: busy=%b want 0", bus.busy);
        end
        // Flush in the SIGN cycle (cycle 33).
        issue(3'd1, 32'd5, 32'd5);
        void'(sb.pop_back());
        for (int c = 1; c < 33; c++) tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sign_busy: busy=%b want 1", bus.busy);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0 || {bus.hi, bus.lo} !== last_exp) begin
            miscompares++;
            $display("FAIL flush_sign: busy/done %0d cycles hi/lo %h want 0 cycles hi/lo %h", seen, {bus.hi, bus.lo}, last_exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc;
        logic [63:0] exp;
        issue(3'd1, 32'd9, 32'd9);
        void'(sb.pop_back());
        tick(); tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b hi/lo=%h want all 0", bus.busy, bus.done, {bus.hi, bus.lo});
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_seq("after_reset", 3'd1, 32'h0001_0000, 32'h0001_0000);
        exp = {32'd1, 32'd0};
        vectors++;
        if ({bus.hi, bus.lo} !== exp) begin
            miscompares++;
            $display("FAIL after_reset_const: got %h want %h", {bus.hi, bus.lo}, exp);
        end
        cyc = 0; bc = 0;
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_edge();
        test_mthi_mtlo();
        test_busy_ignore();
        test_flush();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
